// File: rtl/nn_ctrl_pkg.sv
// Shared types for the layer sequencer: FSM state encoding,
// default data width and the ReLU helper.
package nn_ctrl_pkg;

    localparam int DEF_W = 32;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WRITE     = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    // ReLU keeps a two's-complement value only when its sign bit is clear.
    function automatic logic relu_keep(input logic msb);
        return !msb;
    endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// Layer sequencer bundle: controller go/done, inner-product
// start/ready handshake and output-buffer write port.
interface layer_sequencer_if
    import nn_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int AW = 8
);
    logic          go;
    logic          busy;
    logic          done;
    logic          ip_start;
    logic          ip_ready;
    logic [W-1:0]  ip_result;
    logic [31:0]   neuron_sel;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    modport master (
        input  go, ip_ready, ip_result,
        output busy, done, ip_start, neuron_sel,
        output wr_en, wr_addr, wr_data
    );

    modport slave (
        output go, ip_ready, ip_result,
        input  busy, done, ip_start, neuron_sel,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/seq_index_counter.sv
// Neuron index counter: synchronous clear, enable, saturates at
// M-1 and flags the terminal neuron.
module seq_index_counter #(
    parameter int M  = 10,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [IW-1:0] idx,
    output logic          last
);
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    assign last = (idx == LAST_IDX);

    // Index register; never advances past the last neuron.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idx <= '0;
        else if (clr)
            idx <= '0;
        else if (en && !last)
            idx <= idx + IW'(1);
    end
endmodule

// File: rtl/layer_sequencer.sv
// Runs one inner-product computation per neuron of a layer and writes
// each result to the output buffer. Define RELU_EN to apply ReLU.
module layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int M  = 10,
    parameter int W  = DEF_W,
    parameter int AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    layer_sequencer_if.master  bus
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;

    state_t        state;
    state_t        state_nx;
    logic          pending;
    logic          pending_nx;
    logic          idx_clr;
    logic          idx_en;
    logic          idx_last;
    logic [IW-1:0] idx;
    logic          cap;
    logic [W-1:0]  cap_val;
    logic [W-1:0]  wr_q;

    seq_index_counter #(
        .M  (M),
        .IW (IW)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .en   (idx_en),
        .idx  (idx),
        .last (idx_last)
    );

`ifdef RELU_EN
    assign cap_val = bus.ip_result & {W{relu_keep(bus.ip_result[W-1])}};
`else
    assign cap_val = bus.ip_result;
`endif

    // State and deferred-start flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
        end
    end

    // Next-state logic; a go seen while the unit is busy is
    // remembered until the unit reports idle.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        idx_clr    = 1'b0;
        idx_en     = 1'b0;
        cap        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if ((bus.go || pending) && bus.ip_ready) begin
                    state_nx   = S_ISSUE;
                    pending_nx = 1'b0;
                    idx_clr    = 1'b1;
                end else if (bus.go) begin
                    pending_nx = 1'b1;
                end
            end
            S_ISSUE: state_nx = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (!bus.ip_ready)
                    state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.ip_ready) begin
                    state_nx = S_WRITE;
                    cap      = 1'b1;
                end
            end
            S_WRITE: begin
                idx_en   = !idx_last;
                state_nx = idx_last ? S_FINISH : S_ISSUE;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Result capture on the edge where the unit reports completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_q <= '0;
        else if (cap)
            wr_q <= cap_val;
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_FINISH);
    assign bus.ip_start   = (state == S_ISSUE);
    assign bus.wr_en      = (state == S_WRITE);
    assign bus.neuron_sel = 32'(idx);
    assign bus.wr_addr    = AW'(idx);
    assign bus.wr_data    = wr_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: an M=4 and an M=1 instance
// share one behavioural inner-product model.
module tb_layer_sequencer;
    localparam int W  = 32;
    localparam int AW = 8;

    typedef struct {
        int           addr;
        logic [W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_sequencer_if #(.W(W), .AW(AW)) b4 ();
    layer_sequencer_if #(.W(W), .AW(AW)) b1 ();

    layer_sequencer #(.M(4), .W(W), .AW(AW)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.master)
    );

    layer_sequencer #(.M(1), .W(W), .AW(AW)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.master)
    );

    // stimulus / model state
    logic         go4 = 1'b0;
    logic         go1 = 1'b0;
    logic         sel1 = 1'b0;
    logic         ready_m = 1'b1;
    logic         hold_low = 1'b0;
    logic [W-1:0] res_r = '0;
    int           busy_n = 12;
    logic [W-1:0] res_q[$];
    logic [W-1:0] exp_q[$];

    assign b4.go        = go4;
    assign b1.go        = go1;
    assign b4.ip_ready  = ready_m & ~hold_low;
    assign b1.ip_ready  = ready_m & ~hold_low;
    assign b4.ip_result = res_r;
    assign b1.ip_result = res_r;

    wire start_a = sel1 ? b1.ip_start : b4.ip_start;

    // monitor state
    int  cyc = 0;
    int  n_start, n_done, prot_err, first_start, last_wr, done_cyc;
    bit  prev_start = 1'b0;
    wr_t wq[$];

    int n_cmp = 0;
    int n_bad = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Inner-product unit: ready drops the cycle after start, stays low
    // busy_n cycles, then rises with the next queued result.
    initial forever begin
        @(negedge clk);
        if (start_a) begin
            @(posedge clk);
            #1 ready_m = 1'b0;
            repeat (busy_n) @(posedge clk);
            #1;
            if (res_q.size() > 0) res_r = res_q.pop_front();
            else res_r = '0;
            ready_m = 1'b1;
        end
    end

    // Event recorder for the active instance.
    initial forever begin
        logic s, r, we, dn;
        int   a;
        logic [W-1:0] d;
        @(negedge clk);
        s  = sel1 ? b1.ip_start : b4.ip_start;
        r  = sel1 ? b1.ip_ready : b4.ip_ready;
        we = sel1 ? b1.wr_en : b4.wr_en;
        dn = sel1 ? b1.done : b4.done;
        a  = sel1 ? int'(b1.wr_addr) : int'(b4.wr_addr);
        d  = sel1 ? b1.wr_data : b4.wr_data;
        if (s) begin
            if (n_start == 0) first_start = cyc;
            n_start++;
            if (prev_start || !r) prot_err++;
        end
        prev_start = s;
        if (we) begin
            wq.push_back('{addr: a, data: d});
            last_wr = cyc;
        end
        if (dn) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_out(input logic [W-1:0] r);
`ifdef RELU_EN
        return ($signed(r) < 0) ? '0 : r;
`else
        return r;
`endif
    endfunction

    task automatic clr_mon();
        n_start = 0;
        n_done = 0;
        prot_err = 0;
        first_start = 0;
        last_wr = 0;
        done_cyc = 0;
        wq.delete();
    endtask

    task automatic load(input logic [W-1:0] v);
        res_q.push_back(v);
        exp_q.push_back(ref_out(v));
    endtask

    task automatic pulse_go(input bit one);
        @(posedge clk);
        #1;
        if (one) go1 = 1'b1;
        else go4 = 1'b1;
        @(posedge clk);
        #1;
        go1 = 1'b0;
        go4 = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit && n_done == 0; i++) @(negedge clk);
        chk({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
    endtask

    task automatic wait_wr(input int n, input int limit);
        for (int i = 0; i < limit && wq.size() < n; i++) @(negedge clk);
        chk("wr_progress", 64'(wq.size() >= n), 64'd1);
    endtask

    // Full-layer check against the reference: m writes at 0..m-1 with
    // the expected data, one done right after the last write, latency
    // m*(busy+3) from first start to done, and idle afterwards.
    task automatic check_layer(input string tag, input bit one,
                               input int m, input int nb);
        wait_done(tag, 4000);
        repeat (8) @(negedge clk);
        chk({tag, "_starts"}, 64'(n_start), 64'(m));
        chk({tag, "_dones"}, 64'(n_done), 64'd1);
        chk({tag, "_writes"}, 64'(wq.size()), 64'(m));
        for (int i = 0; i < m && i < wq.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(wq[i].addr), 64'(i));
            chk($sformatf("%s_data%0d", tag, i), 64'(wq[i].data),
                64'(exp_q[i]));
        end
        chk({tag, "_done_after_wr"}, 64'(done_cyc - last_wr), 64'd1);
        chk({tag, "_latency"}, 64'(done_cyc - first_start),
            64'(m * (nb + 3)));
        chk({tag, "_protocol"}, 64'(prot_err), 64'd0);
        chk({tag, "_busy_low"}, 64'(one ? b1.busy : b4.busy), 64'd0);
        chk({tag, "_sel_last"},
            64'(one ? b1.neuron_sel : b4.neuron_sel), 64'(m - 1));
        exp_q.delete();
        res_q.delete();
    endtask

    initial begin
        int rel;
        clr_mon();

        // reset state
        #2;
        chk("rst_busy", 64'(b4.busy), 64'd0);
        chk("rst_done", 64'(b4.done), 64'd0);
        chk("rst_start", 64'(b4.ip_start), 64'd0);
        chk("rst_wr_en", 64'(b4.wr_en), 64'd0);
        chk("rst_sel", 64'(b4.neuron_sel), 64'd0);
        chk("rst_addr", 64'(b4.wr_addr), 64'd0);
        chk("rst_data", 64'(b4.wr_data), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // nominal layer
        busy_n = 12;
        load(32'd5);
        load(-32'sd3);
        load(32'd7);
        load(32'd0);
        pulse_go(1'b0);
        check_layer("nominal", 1'b0, 4, 12);

        // randomized layers
        for (int t = 0; t < 3; t++) begin
            clr_mon();
            busy_n = $urandom_range(1, 6);
            for (int i = 0; i < 4; i++) load($urandom());
            pulse_go(1'b0);
            check_layer($sformatf("rand%0d", t), 1'b0, 4, busy_n);
        end

        // go while the unit is not ready
        clr_mon();
        busy_n = 3;
        for (int i = 0; i < 4; i++) load($urandom());
        @(posedge clk);
        #1 hold_low = 1'b1;
        pulse_go(1'b0);
        repeat (5) @(negedge clk);
        chk("pend_no_start", 64'(n_start), 64'd0);
        chk("pend_busy", 64'(b4.busy), 64'd0);
        @(posedge clk);
        #1 hold_low = 1'b0;
        rel = cyc;
        wait_done("pend", 4000);
        chk("pend_start_lat", 64'(first_start - rel), 64'd1);
        clr_mon();
        exp_q.delete();
        res_q.delete();
        repeat (20) @(negedge clk);
        chk("pend_cleared", 64'(n_start), 64'd0);

        // go pulsed mid-layer
        clr_mon();
        busy_n = 4;
        for (int i = 0; i < 4; i++) load($urandom());
        pulse_go(1'b0);
        wait_wr(2, 500);
        pulse_go(1'b0);
        check_layer("midgo", 1'b0, 4, 4);
        repeat (20) @(negedge clk);
        chk("midgo_no_restart", 64'(n_start), 64'd4);

        // reset during WAIT_DONE of neuron 1
        clr_mon();
        busy_n = 12;
        load(32'd5);
        load(32'd9);
        load(32'd11);
        load(32'd13);
        pulse_go(1'b0);
        wait_wr(1, 500);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(b4.busy), 64'd0);
        chk("abort_sel", 64'(b4.neuron_sel), 64'd0);
        chk("abort_data", 64'(b4.wr_data), 64'd0);
        chk("abort_wr_en", 64'(b4.wr_en), 64'd0);
        repeat (busy_n + 4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_writes", 64'(wq.size()), 64'd1);
        chk("abort_dones", 64'(n_done), 64'd0);
        clr_mon();
        exp_q.delete();
        res_q.delete();
        busy_n = 2;
        for (int i = 0; i < 4; i++) load($urandom());
        pulse_go(1'b0);
        check_layer("restart", 1'b0, 4, 2);

        // single-neuron layer
        clr_mon();
        sel1 = 1'b1;
        busy_n = 1;
        load($urandom());
        pulse_go(1'b1);
        check_layer("m1", 1'b1, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Initiator side of the inner-product start/ready handshake. Drives one neuron computation at a time on the inner-product unit for a layer of M neurons: pulses ip_start, waits for ip_ready to fall and then rise, captures ip_result, and writes it to the layer output buffer. Sits between the top-level network controller (go/done) and the per-neuron inner-product datapath. Also supplies the weight-bank select (neuron_sel).

Parameters:
M, 10, neurons per layer (M >= 1)
W, 32, result/data width
AW, 8, output-buffer address width (2^AW >= M)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
go  in  1  layer start request, sampled in IDLE only
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last neuron is written
ip_start  out  1  one-cycle start pulse to the inner-product unit
ip_ready  in  1  inner-product unit idle/result valid (high in its idle state)
ip_result  in  W  accumulator value, valid while ip_ready=1 after a run
neuron_sel  out  32  current neuron index, zero-extended; selects the weight bank
wr_en  out  1  output-buffer write strobe
wr_addr  out  AW  write address = neuron index
wr_data  out  W  captured (optionally activated) result

Behaviour:
- Reset: state=IDLE; busy=0, done=0, ip_start=0, wr_en=0, neuron_sel=0, wr_addr=0, wr_data=0, pending=0. Reset mid-layer aborts immediately. No write or done is emitted.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WRITE, FINISH. Moore outputs except where noted.
- IDLE: go=1 and ip_ready=1 -> ISSUE, index cleared to 0.
- IDLE, go=1 with ip_ready=0: set pending. Leave once ip_ready=1 (go need not still be high). pending clears on entry to ISSUE.
- ISSUE: ip_start=1 for exactly this cycle -> WAIT_ACK.
- WAIT_ACK: stay while ip_ready=1. On ip_ready=0 -> WAIT_DONE. The inner-product unit drops ready the cycle after start, so normally one cycle is spent here.
- WAIT_DONE: stay while ip_ready=0. On ip_ready=1, capture ip_result into wr_data on that edge -> WRITE.
- WRITE: wr_en=1, wr_addr=index, wr_data held.
  - index==M-1 -> FINISH.
  - Otherwise index+1 -> ISSUE. neuron_sel updates on the same edge.
- FINISH: done=1 for one cycle -> IDLE. index is retained; neuron_sel shows M-1 until the next go.
- Per-neuron latency: ISSUE(1) + WAIT_ACK(1) + ip busy time + WRITE(1). Layer latency is the sum over neurons + 1 (FINISH).
- go while busy=1 is ignored and not queued.
- ip_start is never reasserted before ip_ready has been seen low then high.
- M=1: single ISSUE..WRITE pass, then FINISH.
- Index counter width = clog2(M), minimum 1. Never wraps past M-1.

Optional Feature:
RELU_EN
- Defined: captured value is passed through ReLU before wr_data: MSB=1 (negative, two's complement) -> 0, else unchanged.
- Undefined: raw ip_result is written. Timing identical in both builds.

Decomposition:
- Package nn_ctrl_pkg: state encoding constants (3-bit), ReLU helper function, default W.
- One sub-module, seq_index_counter: clear, enable, terminal flag at M-1. Drives neuron_sel and wr_addr.

Test Plan:
- Nominal, M=4, ip model busy 12 cycles, results 5,-3,7,0 -> 4 ip_start pulses; writes addr0..3 = 5,-3,7,0 (RELU_EN: 5,0,7,0); one done pulse; busy low after.
- go while ip_ready=0 for 6 cycles -> no ip_start until ip_ready=1, then ip_start the following cycle; pending cleared.
- go pulsed mid-layer (neuron 2 of 4) -> ignored; exactly 4 writes, 1 done.
- rst asserted in WAIT_DONE of neuron 1 -> all outputs 0 at once; no wr_en/done; a later go restarts at index 0.
- M=1, ip busy 1 cycle -> sequence ISSUE, WAIT_ACK, WAIT_DONE, WRITE(addr0), FINISH; done 1 cycle after wr_en.
- Assertion: ip_start never high in two consecutive cycles, nor high while ip_ready=0.
